// File: rtl/sync_fifo.sv
// First-word fall-through FIFO: the head entry is presented combinationally from the storage array.
// The caller qualifies push/pop against full/empty; dout reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries are unreachable while count is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU <-> UART byte buffering: a TX FIFO fed by CPU stores and an RX FIFO fed by the UART receiver.
// Holds the push/pop qualification, datapath stall gating and the sticky RX overflow flag.
module uart_fifo_bridge #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              Stall,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              DataInValid,
  output logic              DataInReady,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOutValid,
  input  logic              DataOutReady,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [DATA_W-1:0] uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              rx_overflow,
  input  logic              overflow_clr
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic                rx_push, rx_pop, rx_full, rx_empty;
  logic                rx_drop;
  logic [DEPTH_LOG2:0] tx_count, rx_count;

  // TX refuses pushes when full; RX accepts a byte into a full FIFO only if the head leaves this cycle.
  assign tx_push = DataInValid & ~Stall & ~tx_full;
  assign tx_pop  = ~tx_empty & uart_tx_ready;
  assign rx_pop  = DataOutReady & ~Stall & ~rx_empty;
  assign rx_push = uart_rx_valid & (~rx_full | rx_pop);
  assign rx_drop = uart_rx_valid & rx_full & ~rx_pop;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) tx_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (DataIn),
    .dout  (uart_tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) rx_fifo (
    .clk   (CLK),
    .rst_n (reset_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_rx_data),
    .dout  (DataOut),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // A drop in the same cycle as a clear wins, so no overflow event is ever lost.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n)          rx_overflow <= 1'b0;
    else if (rx_drop)      rx_overflow <= 1'b1;
    else if (overflow_clr) rx_overflow <= 1'b0;
  end

  assign DataInReady   = ~tx_full;
  assign uart_tx_valid = ~tx_empty;
  assign DataOutValid  = ~rx_empty;

  count_bound_tx: assert property (@(posedge CLK) disable iff (!reset_n) tx_count <= FULL_COUNT);
  count_bound_rx: assert property (@(posedge CLK) disable iff (!reset_n) rx_count <= FULL_COUNT);

endmodule
